pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; the chunk width CW = WIDTH/STAGES.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  the operand beat is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; in subtract mode it is the borrow-in.
REQ-010 sub  input  1  operation select: 1 = A-B-cin, 0 = A+B+cin.
REQ-011 out_valid  output  1  the result beat is valid.
REQ-012 out_ready  input  1  the downstream consumer accepts the result.
REQ-013 sum  output  WIDTH  the result.
REQ-014 cout  output  1  carry-out of the MSB; in subtract mode, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow; present only under REQ-031.

Function
REQ-016 Elaboration shall fail unless WIDTH % STAGES == 0, STAGES >= 1 and CW >= 1.
REQ-017 Effective B' = sub ? ~b : b; the initial carry = cin ^ sub.
REQ-018 Stage k (0..STAGES-1) shall add chunk k of A and B' (bits k*CW .. k*CW+CW-1) plus the carry registered by stage k-1, and register the chunk sum and the chunk carry-out.
REQ-019 Operand chunks not yet consumed and result chunks already produced shall travel in skew registers, so all chunks of one beat appear together at the output.
REQ-020 The pipeline advance signal adv = !out_valid || out_ready; in_ready = adv, combinationally.
REQ-021 When adv = 1, every stage shall shift one place; a beat is captured when in_valid && in_ready.
REQ-022 When adv = 0, all stage registers, valid bits and outputs shall hold unchanged.
REQ-023 The latency from acceptance to out_valid shall be exactly STAGES cycles with no stall; each stall cycle adds one cycle.
REQ-024 The throughput shall be one beat per cycle while out_ready stays 1.
REQ-025 Bubbles (in_valid = 0 on advance) shall propagate as invalid stages; sum and cout are don't-care when out_valid = 0.
REQ-026 sum and cout shall equal, bit for bit, the single-cycle result of A + B' + carry0 over WIDTH+1 bits.
REQ-027 In-flight beats keep their own sub and cin; a change of sub on consecutive beats shall not corrupt either result.
REQ-028 When out_valid && !out_ready, sum, cout and ovf shall stay stable until the transfer completes.

Reset
REQ-029 While rst = 1: every stage valid bit = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0; in_ready then follows REQ-020 and equals 1.
REQ-030 An assertion of rst mid-operation shall discard all in-flight beats; the first beat after release shall complete normally.

Configuration
REQ-031 Macro PIPE_ADDER_OVF_EN defined: the ovf port exists and equals carry-into-MSB XOR carry-out-of-MSB, aligned with sum.
- Without the macro, the ovf port and its logic shall be absent.

Structure
REQ-032 A shared package shall hold the function computing CW, plus the localparam defaults for WIDTH and STAGES.
REQ-033 A single sub-module, adder_chunk (parametrised CW-bit ripple add with carry in/out, combinational), is instantiated once per stage.
- The pipeline and skew registers live in the top module.

Verification (WIDTH=64, STAGES=4)
REQ-034 a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> after 4 cycles: sum=0, cout=1, ovf=0.
REQ-035 a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, cout=0, ovf=1 (macro on).
REQ-036 a=5, b=7, sub=1, cin=0 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-037 Back-to-back beats 1+1, 2+2, 3+3 with out_ready=1 -> sums 2, 4, 6 on 3 consecutive cycles.
- Then hold out_ready=0 for 3 cycles -> outputs held and in_ready=0; on release, no beat is lost or duplicated.
REQ-038 Three beats in flight, assert rst for 1 cycle -> out_valid=0 immediately; next beat 10+20 -> sum=30 after 4 cycles.
REQ-039 10k random beats with random sub, cin, in_valid and out_ready -> every result matches the reference model, in order.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and chunk-width helper for the pipelined adder.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_STAGES = 4;

  function automatic int calc_cw(input int width, input int stages);
    return (stages >= 1) ? width / stages : 0;
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational CW-bit add with carry in/out; one instance per pipeline stage.
module adder_chunk #(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// Carry-chunked pipelined adder/subtractor with valid/ready flow control.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = calc_cw(WIDTH, STAGES);

  if ((STAGES < 1) || (CW < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic adv;

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] bb_q, bb_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0]            c_q, c_d;

  // Per-stage inputs: stage 0 sees the port, later stages see the previous register.
  logic [STAGES-1:0]            op_v;
  logic [STAGES-1:0][WIDTH-1:0] op_a;
  logic [STAGES-1:0][WIDTH-1:0] op_b;
  logic [STAGES-1:0]            op_c;
  logic [STAGES-1:0][WIDTH-1:0] part;
  logic [STAGES-1:0][CW-1:0]    ch_sum;
  logic [STAGES-1:0]            ch_co;

  assign out_valid = vld_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_in
      assign op_v[k] = in_valid;
      assign op_a[k] = a;
      assign op_b[k] = sub ? ~b : b;
      assign op_c[k] = cin ^ sub;
      assign part[k] = '0;
    end else begin : g_fwd
      assign op_v[k] = vld_q[k-1];
      assign op_a[k] = a_q[k-1];
      assign op_b[k] = bb_q[k-1];
      assign op_c[k] = c_q[k-1];
      assign part[k] = sum_q[k-1];
    end

    adder_chunk #(.CW(CW)) u_chunk (
      .a  (op_a[k][k*CW +: CW]),
      .b  (op_b[k][k*CW +: CW]),
      .ci (op_c[k]),
      .s  (ch_sum[k]),
      .co (ch_co[k])
    );
  end

  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    bb_d  = bb_q;
    sum_d = sum_q;
    c_d   = c_q;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_d[k]              = op_v[k];
        a_d[k]                = op_a[k];
        bb_d[k]               = op_b[k];
        sum_d[k]              = part[k];
        sum_d[k][k*CW +: CW]  = ch_sum[k];
        c_d[k]                = ch_co[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      bb_q  <= '0;
      sum_q <= '0;
      c_q   <= '0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      bb_q  <= bb_d;
      sum_q <= sum_d;
      c_q   <= c_d;
    end
  end

  assign sum  = sum_q[STAGES-1];
  assign cout = c_q[STAGES-1];

  // Operands leaving the last stage have no further consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], bb_q[STAGES-1]};

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
  always_comb begin
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = op_a[STAGES-1][WIDTH-1] ^ op_b[STAGES-1][WIDTH-1]
            ^ ch_sum[STAGES-1][CW-1] ^ ch_co[STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule
